vram_port_arbiter: RTL and testbench

- Shares the single-port video RAM between three requesters:
  - CPU writes arriving from the memory-mapped IO bus decode for the 0xD region (we/addr/data strobes).
  - Display scan-out reads.
  - An internal hardware clear engine.
- CPU writes cannot stall the bus, so they are buffered in a small FIFO and drained when the port is free.
- Sits between the IO bus decoder, the VGA timing/pixel block and the VRAM instance.

---
 rtl/vram_port_arbiter_if.sv | 41 ++++
 rtl/vram_port_arbiter.sv | 139 +++++++++++++
 tb/tb_vram_port_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_port_arbiter_if.sv
// Bus bundle between the VRAM port arbiter and its neighbours: the CPU write path,
// display read path, clear-engine control, FIFO status and the raw VRAM port.
interface vram_port_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
);
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_waddr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              vga_re;
    logic [ADDR_W-1:0] vga_raddr;
    logic [DATA_W-1:0] vga_rdata;
    logic              vga_rvalid;
    logic              clr_start;
    logic [DATA_W-1:0] clr_data;
    logic              clr_busy;
    logic              fifo_full;
    logic              fifo_empty;
    logic              wr_overflow;
    logic              ovf_clr;
    logic [ADDR_W-1:0] vram_addr;
    logic              vram_we;
    logic [DATA_W-1:0] vram_wdata;
    logic [DATA_W-1:0] vram_rdata;

    // Arbiter side
    modport slave (
        input  cpu_we, cpu_waddr, cpu_wdata, vga_re, vga_raddr, clr_start, clr_data,
               ovf_clr, vram_rdata,
        output vga_rdata, vga_rvalid, clr_busy, fifo_full, fifo_empty, wr_overflow,
               vram_addr, vram_we, vram_wdata
    );

    // Surrounding system side
    modport master (
        output cpu_we, cpu_waddr, cpu_wdata, vga_re, vga_raddr, clr_start, clr_data,
               ovf_clr, vram_rdata,
        input  vga_rdata, vga_rvalid, clr_busy, fifo_full, fifo_empty, wr_overflow,
               vram_addr, vram_we, vram_wdata
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// Single-port VRAM sharing: display reads win every cycle, then the clear engine,
// then buffered CPU writes drained in arrival order from a small circular FIFO.
module vram_port_arbiter #(
    parameter int ADDR_W     = 15,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CLR_LAST   = 19199
) (
    input logic                 clk,
    input logic                 rst,
    vram_port_arbiter_if.slave  bus
);
    localparam int                PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] CLR_END  = ADDR_W'(CLR_LAST);
    localparam logic [PTR_W:0]    CNT_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {ST_IDLE, ST_CLEAR} clr_state_t;

    clr_state_t        clr_state;
    logic              clr_busy_r;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] clr_fill;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    fifo_cnt;
    logic [PTR_W:0]    fifo_cnt_nxt;
    logic              fifo_full_r;
    logic              fifo_empty_r;
    logic              wr_overflow_r;
    logic              vga_rvalid_r;

    logic              grant_vga;
    logic              grant_clr;
    logic              grant_fifo;
    logic              push;
    logic              drop;

    // Grants are masked during reset so the VRAM port is quiet immediately.
    always_comb begin
        grant_vga    = !rst && bus.vga_re;
        grant_clr    = !rst && !bus.vga_re && clr_busy_r;
        grant_fifo   = !rst && !bus.vga_re && !clr_busy_r && !fifo_empty_r;
        push         = bus.cpu_we && (!fifo_full_r || grant_fifo);
        drop         = bus.cpu_we && fifo_full_r && !grant_fifo;
        fifo_cnt_nxt = fifo_cnt + (PTR_W + 1)'(push) - (PTR_W + 1)'(grant_fifo);
    end

    always_comb begin
        bus.vram_addr  = '0;
        bus.vram_wdata = '0;
        bus.vram_we    = 1'b0;
        if (grant_vga) begin
            bus.vram_addr  = bus.vga_raddr;
        end else if (grant_clr) begin
            bus.vram_addr  = clr_cnt;
            bus.vram_wdata = clr_fill;
            bus.vram_we    = 1'b1;
        end else if (grant_fifo) begin
            bus.vram_addr  = fifo_addr[rd_ptr];
            bus.vram_wdata = fifo_data[rd_ptr];
            bus.vram_we    = 1'b1;
        end
    end

    // FIFO payload and clear fill value carry no reset; their qualifiers do.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= bus.cpu_waddr;
            fifo_data[wr_ptr] <= bus.cpu_wdata;
        end
        if (clr_state == ST_IDLE && bus.clr_start) begin
            clr_fill <= bus.clr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            fifo_full_r   <= 1'b0;
            fifo_empty_r  <= 1'b1;
            wr_overflow_r <= 1'b0;
            vga_rvalid_r  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (grant_fifo) rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt     <= fifo_cnt_nxt;
            fifo_full_r  <= (fifo_cnt_nxt == CNT_FULL);
            fifo_empty_r <= (fifo_cnt_nxt == '0);
            if (drop) begin
                wr_overflow_r <= 1'b1;
            end else if (bus.ovf_clr) begin
                wr_overflow_r <= 1'b0;
            end
            vga_rvalid_r <= bus.vga_re;
        end
    end

    // Clear engine: the counter only advances on cycles it actually owns the port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_state  <= ST_IDLE;
            clr_busy_r <= 1'b0;
            clr_cnt    <= '0;
        end else begin
            case (clr_state)
                ST_IDLE: begin
                    if (bus.clr_start) begin
                        clr_state  <= ST_CLEAR;
                        clr_busy_r <= 1'b1;
                        clr_cnt    <= '0;
                    end
                end
                ST_CLEAR: begin
                    if (grant_clr) begin
                        if (clr_cnt == CLR_END) begin
                            clr_state  <= ST_IDLE;
                            clr_busy_r <= 1'b0;
                            clr_cnt    <= '0;
                        end else begin
                            clr_cnt <= clr_cnt + ADDR_W'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.vga_rdata   = bus.vram_rdata;
    assign bus.vga_rvalid  = vga_rvalid_r;
    assign bus.clr_busy    = clr_busy_r;
    assign bus.fifo_full   = fifo_full_r;
    assign bus.fifo_empty  = fifo_empty_r;
    assign bus.wr_overflow = wr_overflow_r;
endmodule

// File: tb/tb_vram_port_arbiter.sv
// Directed bench for vram_port_arbiter with a behavioural synchronous VRAM attached.
module tb_vram_port_arbiter;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    vram_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vram_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(4), .CLR_LAST(7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [DATA_W-1:0] mem [0:32767];

    always @(posedge clk) begin
        if (bus.vram_we) mem[bus.vram_addr] <= bus.vram_wdata;
        bus.vram_rdata <= mem[bus.vram_addr];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.cpu_we    = 1'b0;
        bus.cpu_waddr = '0;
        bus.cpu_wdata = '0;
        bus.vga_re    = 1'b0;
        bus.vga_raddr = '0;
        bus.clr_start = 1'b0;
        bus.clr_data  = '0;
        bus.ovf_clr   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.vram_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", bus.vram_we); end
        total++; if (bus.vram_addr !== 15'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", bus.vram_addr); end
        total++; if (bus.vram_wdata !== 8'h0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", bus.vram_wdata); end
        total++; if (bus.fifo_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", bus.fifo_empty); end
        total++; if (bus.fifo_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", bus.fifo_full); end
        total++; if (bus.clr_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.clr_busy); end
        total++; if (bus.wr_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", bus.wr_overflow); end
        total++; if (bus.vga_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%b exp=0", bus.vga_rvalid); end
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_single_write();
        cyc();
        bus.cpu_we = 1'b1; bus.cpu_waddr = 15'h0123; bus.cpu_wdata = 8'h5A;
        #1;
        total++; if (bus.vram_we !== 1'b0) begin bad++; $display("FAIL single_pre_we got=%b exp=0", bus.vram_we); end
        cyc();
        bus.cpu_we = 1'b0;
        #1;
        total++; if (bus.vram_we !== 1'b1) begin bad++; $display("FAIL single_we got=%b exp=1", bus.vram_we); end
        total++; if (bus.vram_addr !== 15'h0123) begin bad++; $display("FAIL single_addr got=%h exp=0123", bus.vram_addr); end
        total++; if (bus.vram_wdata !== 8'h5A) begin bad++; $display("FAIL single_wdata got=%h exp=5a", bus.vram_wdata); end
        total++; if (bus.fifo_empty !== 1'b0) begin bad++; $display("FAIL single_nonempty got=%b exp=0", bus.fifo_empty); end
        cyc();
        #1;
        total++; if (bus.vram_we !== 1'b0) begin bad++; $display("FAIL single_post_we got=%b exp=0", bus.vram_we); end
        total++; if (bus.fifo_empty !== 1'b1) begin bad++; $display("FAIL single_empty got=%b exp=1", bus.fifo_empty); end
    endtask

    task automatic test_starvation();
        logic [ADDR_W-1:0] sa [3];
        logic [DATA_W-1:0] sd [3];
        logic              rv;
        sa[0] = 15'h10; sa[1] = 15'h20; sa[2] = 15'h30;
        sd[0] = 8'h11;  sd[1] = 8'h22;  sd[2] = 8'h33;
        for (int i = 1; i <= 14; i++) begin
            cyc();
            bus.vga_re    = (i <= 10);
            bus.vga_raddr = (i == 1) ? 15'h0123 : ADDR_W'(32'h100 + i);
            bus.cpu_we    = (i >= 2 && i <= 4);
            if (i >= 2 && i <= 4) begin
                bus.cpu_waddr = sa[i-2];
                bus.cpu_wdata = sd[i-2];
            end
            #1;
            rv = (i >= 2 && i <= 11);
            total++; if (bus.vga_rvalid !== rv) begin bad++; $display("FAIL starve_rvalid c%0d got=%b exp=%b", i, bus.vga_rvalid, rv); end
            if (i == 2) begin
                total++; if (bus.vga_rdata !== 8'h5A) begin bad++; $display("FAIL starve_rdata got=%h exp=5a", bus.vga_rdata); end
            end
            if (i <= 10) begin
                total++; if (bus.vram_we !== 1'b0) begin bad++; $display("FAIL starve_we c%0d got=%b exp=0", i, bus.vram_we); end
                total++; if (bus.vram_addr !== bus.vga_raddr) begin bad++; $display("FAIL starve_raddr c%0d got=%h exp=%h", i, bus.vram_addr, bus.vga_raddr); end
            end else if (i <= 13) begin
                total++; if (bus.vram_we !== 1'b1) begin bad++; $display("FAIL order_we c%0d got=%b exp=1", i, bus.vram_we); end
                total++; if (bus.vram_addr !== sa[i-11]) begin bad++; $display("FAIL order_addr c%0d got=%h exp=%h", i, bus.vram_addr, sa[i-11]); end
                total++; if (bus.vram_wdata !== sd[i-11]) begin bad++; $display("FAIL order_wdata c%0d got=%h exp=%h", i, bus.vram_wdata, sd[i-11]); end
            end else begin
                total++; if (bus.vram_we !== 1'b0) begin bad++; $display("FAIL order_done_we got=%b exp=0", bus.vram_we); end
                total++; if (bus.fifo_empty !== 1'b1) begin bad++; $display("FAIL order_done_empty got=%b exp=1", bus.fifo_empty); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 14; i++) begin
            cyc();
            bus.vga_re    = (i <= 8);
            bus.vga_raddr = 15'h200;
            bus.cpu_we    = (i <= 5) || (i == 9);
            bus.cpu_waddr = (i == 9) ? 15'h8 : ADDR_W'(i + 3);
            bus.cpu_wdata = (i == 9) ? 8'hA4 : ((i == 5) ? 8'hEE : DATA_W'(8'hA0 + i - 1));
            bus.ovf_clr   = (i == 5) || (i == 7);
            #1;
            if (i == 4) begin
                total++; if (bus.fifo_full !== 1'b0) begin bad++; $display("FAIL ovf_full3 got=%b exp=0", bus.fifo_full); end
            end
            if (i == 5) begin
                total++; if (bus.fifo_full !== 1'b1) begin bad++; $display("FAIL ovf_full4 got=%b exp=1", bus.fifo_full); end
                total++; if (bus.wr_overflow !== 1'b0) begin bad++; $display("FAIL ovf_pre got=%b exp=0", bus.wr_overflow); end
            end
            if (i == 6) begin
                total++; if (bus.wr_overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", bus.wr_overflow); end
            end
            if (i == 8) begin
                total++; if (bus.wr_overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%b exp=0", bus.wr_overflow); end
            end
            if (i <= 8) begin
                total++; if (bus.vram_we !== 1'b0) begin bad++; $display("FAIL ovf_starve_we c%0d got=%b exp=0", i, bus.vram_we); end
            end else if (i <= 13) begin
                total++; if (bus.vram_we !== 1'b1) begin bad++; $display("FAIL drain_we c%0d got=%b exp=1", i, bus.vram_we); end
                total++; if (bus.vram_addr !== ADDR_W'(i - 5)) begin bad++; $display("FAIL drain_addr c%0d got=%h exp=%h", i, bus.vram_addr, i - 5); end
                total++; if (bus.vram_wdata !== DATA_W'(8'hA0 + i - 9)) begin bad++; $display("FAIL drain_wdata c%0d got=%h exp=%h", i, bus.vram_wdata, 8'hA0 + i - 9); end
            end else begin
                total++; if (bus.vram_we !== 1'b0) begin bad++; $display("FAIL drain_done_we got=%b exp=0", bus.vram_we); end
                total++; if (bus.fifo_empty !== 1'b1) begin bad++; $display("FAIL drain_done_empty got=%b exp=1", bus.fifo_empty); end
            end
            if (i == 10) begin
                total++; if (bus.fifo_full !== 1'b1) begin bad++; $display("FAIL pushpop_full got=%b exp=1", bus.fifo_full); end
                total++; if (bus.wr_overflow !== 1'b0) begin bad++; $display("FAIL pushpop_ovf got=%b exp=0", bus.wr_overflow); end
            end
            if (i == 11) begin
                total++; if (bus.fifo_full !== 1'b0) begin bad++; $display("FAIL drain_notfull got=%b exp=0", bus.fifo_full); end
            end
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        for (int i = 1; i <= 11; i++) begin
            cyc();
            bus.clr_start = (i == 1);
            bus.clr_data  = 8'h00;
            bus.cpu_we    = (i == 2);
            bus.cpu_waddr = 15'h3;
            bus.cpu_wdata = 8'hAA;
            #1;
            if (i == 1) begin
                total++; if (bus.clr_busy !== 1'b0) begin bad++; $display("FAIL clr_start_busy got=%b exp=0", bus.clr_busy); end
                total++; if (bus.vram_we !== 1'b0) begin bad++; $display("FAIL clr_start_we got=%b exp=0", bus.vram_we); end
            end else if (i <= 9) begin
                total++; if (bus.clr_busy !== 1'b1) begin bad++; $display("FAIL clr_busy c%0d got=%b exp=1", i, bus.clr_busy); end
                total++; if (bus.vram_we !== 1'b1) begin bad++; $display("FAIL clr_we c%0d got=%b exp=1", i, bus.vram_we); end
                total++; if (bus.vram_addr !== ADDR_W'(i - 2)) begin bad++; $display("FAIL clr_addr c%0d got=%h exp=%h", i, bus.vram_addr, i - 2); end
                total++; if (bus.vram_wdata !== 8'h00) begin bad++; $display("FAIL clr_wdata c%0d got=%h exp=00", i, bus.vram_wdata); end
            end else if (i == 10) begin
                total++; if (bus.clr_busy !== 1'b0) begin bad++; $display("FAIL clr_end_busy got=%b exp=0", bus.clr_busy); end
                total++; if (bus.vram_we !== 1'b1) begin bad++; $display("FAIL clr_cpu_we got=%b exp=1", bus.vram_we); end
                total++; if (bus.vram_addr !== 15'h3) begin bad++; $display("FAIL clr_cpu_addr got=%h exp=3", bus.vram_addr); end
                total++; if (bus.vram_wdata !== 8'hAA) begin bad++; $display("FAIL clr_cpu_wdata got=%h exp=aa", bus.vram_wdata); end
            end else begin
                total++; if (bus.vram_we !== 1'b0) begin bad++; $display("FAIL clr_idle_we got=%b exp=0", bus.vram_we); end
            end
        end
        idle_inputs();
        total++; if (mem[3] !== 8'hAA) begin bad++; $display("FAIL clr_mem3 got=%h exp=aa", mem[3]); end
        total++; if (mem[5] !== 8'h00) begin bad++; $display("FAIL clr_mem5 got=%h exp=00", mem[5]); end
        total++; if (mem[8] !== 8'hA4) begin bad++; $display("FAIL clr_mem8 got=%h exp=a4", mem[8]); end
    endtask

    task automatic test_clear_vga();
        int  wcnt [8];
        int  ea;
        for (int a = 0; a < 8; a++) wcnt[a] = 0;
        for (int i = 1; i <= 18; i++) begin
            cyc();
            bus.clr_start = (i == 1) || (i == 6);
            bus.clr_data  = (i == 1) ? 8'h77 : 8'h11;
            bus.vga_re    = (i >= 2 && i <= 16 && (i % 2) == 0);
            bus.vga_raddr = 15'h300;
            #1;
            if (i == 1) begin
                total++; if (bus.clr_busy !== 1'b0) begin bad++; $display("FAIL cv_start_busy got=%b exp=0", bus.clr_busy); end
            end else if (i <= 17) begin
                total++; if (bus.clr_busy !== 1'b1) begin bad++; $display("FAIL cv_busy c%0d got=%b exp=1", i, bus.clr_busy); end
                if (bus.vga_re) begin
                    total++; if (bus.vram_we !== 1'b0) begin bad++; $display("FAIL cv_vga_we c%0d got=%b exp=0", i, bus.vram_we); end
                end else begin
                    ea = (i - 3) / 2;
                    total++; if (bus.vram_we !== 1'b1) begin bad++; $display("FAIL cv_we c%0d got=%b exp=1", i, bus.vram_we); end
                    total++; if (bus.vram_addr !== ADDR_W'(ea)) begin bad++; $display("FAIL cv_addr c%0d got=%h exp=%h", i, bus.vram_addr, ea); end
                    total++; if (bus.vram_wdata !== 8'h77) begin bad++; $display("FAIL cv_wdata c%0d got=%h exp=77", i, bus.vram_wdata); end
                end
            end else begin
                total++; if (bus.clr_busy !== 1'b0) begin bad++; $display("FAIL cv_end_busy got=%b exp=0", bus.clr_busy); end
                total++; if (bus.vram_we !== 1'b0) begin bad++; $display("FAIL cv_end_we got=%b exp=0", bus.vram_we); end
            end
            if (bus.vram_we === 1'b1 && int'(bus.vram_addr) < 8) wcnt[int'(bus.vram_addr)]++;
        end
        idle_inputs();
        for (int a = 0; a < 8; a++) begin
            total++; if (wcnt[a] !== 1) begin bad++; $display("FAIL cv_once a%0d got=%0d exp=1", a, wcnt[a]); end
        end
    endtask

    task automatic test_reset_midrun();
        for (int i = 1; i <= 6; i++) begin
            cyc();
            bus.clr_start = (i == 1);
            bus.clr_data  = 8'h5C;
            bus.vga_re    = 1'b1;
            bus.vga_raddr = 15'h55;
            bus.cpu_we    = (i <= 5);
            bus.cpu_waddr = ADDR_W'(32'h60 + i);
            bus.cpu_wdata = DATA_W'(i);
        end
        #1;
        total++; if (bus.clr_busy !== 1'b1) begin bad++; $display("FAIL mid_busy got=%b exp=1", bus.clr_busy); end
        total++; if (bus.wr_overflow !== 1'b1) begin bad++; $display("FAIL mid_ovf got=%b exp=1", bus.wr_overflow); end
        total++; if (bus.fifo_full !== 1'b1) begin bad++; $display("FAIL mid_full got=%b exp=1", bus.fifo_full); end
        #2;
        rst = 1'b1;
        #1;
        total++; if (bus.vram_we !== 1'b0) begin bad++; $display("FAIL rst_we got=%b exp=0", bus.vram_we); end
        total++; if (bus.vram_addr !== 15'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", bus.vram_addr); end
        total++; if (bus.fifo_empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", bus.fifo_empty); end
        total++; if (bus.fifo_full !== 1'b0) begin bad++; $display("FAIL rst_full got=%b exp=0", bus.fifo_full); end
        total++; if (bus.clr_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.clr_busy); end
        total++; if (bus.wr_overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got=%b exp=0", bus.wr_overflow); end
        total++; if (bus.vga_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b exp=0", bus.vga_rvalid); end
        idle_inputs();
        cyc();
        rst = 1'b0;
        cyc();
        #1;
        total++; if (bus.vram_we !== 1'b0) begin bad++; $display("FAIL post_rst_we got=%b exp=0", bus.vram_we); end
        total++; if (bus.clr_busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy got=%b exp=0", bus.clr_busy); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_starvation();
        test_overflow();
        test_clear();
        test_clear_vga();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
